// File: rtl/axi_burst_splitter_pkg.sv
// Shared types and helpers for the AXI burst splitter.
// Optional SVA checks: define AXI_BURST_SPLITTER_ASSERT_EN.
package axi_burst_splitter_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_BEAT,
    W_BWAIT,
    W_BRESP
  } wr_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Error codes outrank OKAY, so the numerically larger one wins.
  function automatic logic [1:0] resp_merge(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_splitter_addr_gen.sv
// Next-beat address for one downstream single-beat transfer.
// FIXED holds; INCR and WRAP align then step by 1<<size.
module axi_beat_addr_gen
  import axi_burst_splitter_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] step;

  always_comb begin
    step = AW'(1) << size;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else begin
      next_addr = (addr & ~(step - AW'(1))) + step;
    end
  end

endmodule

// File: rtl/axi_burst_splitter.sv
// Splits AXI bursts into single-beat downstream transfers.
// Optional SVA checks: define AXI_BURST_SPLITTER_ASSERT_EN.
module axi_burst_splitter
  import axi_burst_splitter_pkg::*;
#(
  parameter int TAGW = 1,
  parameter int AW   = 32,
  parameter int DW   = 64
) (
  input  logic            aclk,
  input  logic            rst_l,
  input  logic            s_arvalid,
  output logic            s_arready,
  input  logic [AW-1:0]   s_araddr,
  input  logic [TAGW-1:0] s_arid,
  input  logic [7:0]      s_arlen,
  input  logic [1:0]      s_arburst,
  input  logic [2:0]      s_arsize,
  output logic            s_rvalid,
  input  logic            s_rready,
  output logic [DW-1:0]   s_rdata,
  output logic [1:0]      s_rresp,
  output logic [TAGW-1:0] s_rid,
  output logic            s_rlast,
  input  logic            s_awvalid,
  output logic            s_awready,
  input  logic [AW-1:0]   s_awaddr,
  input  logic [TAGW-1:0] s_awid,
  input  logic [7:0]      s_awlen,
  input  logic [1:0]      s_awburst,
  input  logic [2:0]      s_awsize,
  input  logic            s_wvalid,
  output logic            s_wready,
  input  logic [DW-1:0]   s_wdata,
  input  logic [DW/8-1:0] s_wstrb,
  input  logic            s_wlast,
  output logic            s_bvalid,
  input  logic            s_bready,
  output logic [1:0]      s_bresp,
  output logic [TAGW-1:0] s_bid,
  output logic            m_arvalid,
  input  logic            m_arready,
  output logic [AW-1:0]   m_araddr,
  output logic [TAGW-1:0] m_arid,
  output logic [7:0]      m_arlen,
  output logic [1:0]      m_arburst,
  output logic [2:0]      m_arsize,
  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [DW-1:0]   m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic [TAGW-1:0] m_rid,
  input  logic            m_rlast,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [AW-1:0]   m_awaddr,
  output logic [TAGW-1:0] m_awid,
  output logic [7:0]      m_awlen,
  output logic [1:0]      m_awburst,
  output logic [2:0]      m_awsize,
  output logic            m_wvalid,
  input  logic            m_wready,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  output logic            m_wlast,
  input  logic            m_bvalid,
  output logic            m_bready,
  input  logic [1:0]      m_bresp,
  input  logic [TAGW-1:0] m_bid
);

  rd_state_e       rd_st;
  logic [AW-1:0]   r_addr, r_next;
  logic [TAGW-1:0] r_id;
  logic [7:0]      r_len, r_cnt;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic            r_data_st, r_last, r_hs, r_wrap;

  wr_state_e       wr_st;
  logic [AW-1:0]   w_addr, w_next;
  logic [TAGW-1:0] w_id;
  logic [7:0]      w_len, w_cnt;
  logic [2:0]      w_size;
  logic [1:0]      w_burst, acc, b_acc;
  logic            aw_done, w_done, w_fwd;
  logic            w_hs, aw_hs, w_last, wl_bad, w_wrap;

  // Downstream slave echoes neither id nor rlast usefully.
  logic            unused_in;
  assign unused_in = ^{m_rid, m_rlast, m_bid};

  axi_beat_addr_gen #(.AW(AW)) u_rd_addr (
    .addr      (r_addr),
    .size      (r_size),
    .burst     (r_burst),
    .next_addr (r_next)
  );

  axi_beat_addr_gen #(.AW(AW)) u_wr_addr (
    .addr      (w_addr),
    .size      (w_size),
    .burst     (w_burst),
    .next_addr (w_next)
  );

  assign r_data_st = (rd_st == R_DATA);
  assign r_last    = (r_cnt == r_len);
  assign r_wrap    = (r_burst == BURST_WRAP);
  assign r_hs      = r_data_st & m_rvalid & s_rready;

  assign s_rvalid  = r_data_st & m_rvalid;
  assign m_rready  = r_data_st & s_rready;
  assign s_rdata   = r_data_st ? m_rdata : '0;
  assign s_rresp   = r_data_st ?
    resp_merge(m_rresp, r_wrap ? RESP_SLVERR : RESP_OKAY) :
    RESP_OKAY;
  assign s_rid     = r_id;
  assign s_rlast   = r_data_st & r_last;

  assign m_araddr  = r_addr;
  assign m_arid    = r_id;
  assign m_arlen   = 8'd0;
  assign m_arburst = BURST_INCR;
  assign m_arsize  = r_size;

  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      rd_st     <= R_IDLE;
      s_arready <= 1'b0;
      m_arvalid <= 1'b0;
      r_addr    <= '0;
      r_id      <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
    end else begin
      unique case (rd_st)
        R_IDLE: begin
          s_arready <= 1'b1;
          if (s_arvalid && s_arready) begin
            r_addr    <= s_araddr;
            r_id      <= s_arid;
            r_len     <= s_arlen;
            r_size    <= s_arsize;
            r_burst   <= s_arburst;
            r_cnt     <= '0;
            s_arready <= 1'b0;
            m_arvalid <= 1'b1;
            rd_st     <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            rd_st     <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (r_last) begin
              s_arready <= 1'b1;
              rd_st     <= R_IDLE;
            end else begin
              r_cnt     <= r_cnt + 8'd1;
              r_addr    <= r_next;
              m_arvalid <= 1'b1;
              rd_st     <= R_ADDR;
            end
          end
        end
        default: rd_st <= R_IDLE;
      endcase
    end
  end

  assign w_fwd     = (wr_st == W_BEAT) & ~w_done;
  assign w_hs      = w_fwd & s_wvalid & m_wready;
  assign aw_hs     = m_awvalid & m_awready;
  assign w_last    = (w_cnt == w_len);
  assign wl_bad    = (s_wlast != w_last);
  assign w_wrap    = (w_burst == BURST_WRAP);
  assign b_acc     = resp_merge(acc, m_bresp);

  assign m_wvalid  = w_fwd & s_wvalid;
  assign s_wready  = w_fwd & m_wready;
  assign m_wdata   = w_fwd ? s_wdata : '0;
  assign m_wstrb   = w_fwd ? s_wstrb : '0;
  assign m_wlast   = 1'b1;
  assign m_bready  = (wr_st == W_BWAIT);
  assign s_bid     = w_id;

  assign m_awaddr  = w_addr;
  assign m_awid    = w_id;
  assign m_awlen   = 8'd0;
  assign m_awburst = BURST_INCR;
  assign m_awsize  = w_size;

  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      wr_st     <= W_IDLE;
      s_awready <= 1'b0;
      m_awvalid <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      w_addr    <= '0;
      w_id      <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      acc       <= RESP_OKAY;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      unique case (wr_st)
        W_IDLE: begin
          s_awready <= 1'b1;
          if (s_awvalid && s_awready) begin
            w_addr    <= s_awaddr;
            w_id      <= s_awid;
            w_len     <= s_awlen;
            w_size    <= s_awsize;
            w_burst   <= s_awburst;
            w_cnt     <= '0;
            acc       <= RESP_OKAY;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            s_awready <= 1'b0;
            m_awvalid <= 1'b1;
            wr_st     <= W_BEAT;
          end
        end
        W_BEAT: begin
          if (aw_hs) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          // A misplaced wlast flags the burst but never ends it.
          if (w_hs) begin
            w_done <= 1'b1;
            if (wl_bad) acc <= resp_merge(acc, RESP_SLVERR);
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            wr_st <= W_BWAIT;
          end
        end
        W_BWAIT: begin
          if (m_bvalid) begin
            acc <= b_acc;
            if (w_last) begin
              s_bvalid <= 1'b1;
              s_bresp  <= w_wrap ?
                resp_merge(b_acc, RESP_SLVERR) : b_acc;
              wr_st    <= W_BRESP;
            end else begin
              w_cnt     <= w_cnt + 8'd1;
              w_addr    <= w_next;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              m_awvalid <= 1'b1;
              wr_st     <= W_BEAT;
            end
          end
        end
        W_BRESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            wr_st     <= W_IDLE;
          end
        end
        default: wr_st <= W_IDLE;
      endcase
    end
  end

`ifdef AXI_BURST_SPLITTER_ASSERT_EN
  a_ar_hold: assert property (@(posedge aclk) disable iff (!rst_l)
    s_arvalid && !s_arready |=> s_arvalid &&
    $stable({s_araddr, s_arid, s_arlen, s_arburst, s_arsize}));
  a_aw_hold: assert property (@(posedge aclk) disable iff (!rst_l)
    s_awvalid && !s_awready |=> s_awvalid &&
    $stable({s_awaddr, s_awid, s_awlen, s_awburst, s_awsize}));
  a_w_hold: assert property (@(posedge aclk) disable iff (!rst_l)
    s_wvalid && !s_wready |=> s_wvalid &&
    $stable({s_wdata, s_wstrb, s_wlast}));
  a_arsize: assert property (@(posedge aclk) disable iff (!rst_l)
    s_arvalid |-> 32'(s_arsize) <= $clog2(DW/8));
  a_no_x: assert property (@(posedge aclk) disable iff (!rst_l)
    !$isunknown({s_arvalid, s_awvalid, s_wvalid, m_rvalid, m_bvalid}));
  a_wlast: assert property (@(posedge aclk) disable iff (!rst_l)
    w_hs |-> !wl_bad) else $error("wlast does not match beat count");
  a_ar_wrap: assert property (@(posedge aclk) disable iff (!rst_l)
    s_arvalid && s_arready |-> s_arburst != BURST_WRAP)
    else $error("WRAP read burst issued");
  a_aw_wrap: assert property (@(posedge aclk) disable iff (!rst_l)
    s_awvalid && s_awready |-> s_awburst != BURST_WRAP)
    else $error("WRAP write burst issued");
`endif

endmodule
